mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Multi-cycle multiply sequencer for the pipelined RV32 core. It accepts a `mul` from the EX stage and computes the low XLEN bits of the product with an iterative shift-add datapath, one multiplier bit per cycle. While it works it stalls the front of the pipeline, then hands the result and destination register to EX/MEM. It sits beside the ALU and is enabled by the R-type decode path (opcode 0110011, funct7 0000001, funct3 000).

## Interface
- `XLEN`, 32, operand and result width.
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `start_i`  input  1  a `mul` instruction is valid in EX this cycle.
- `flush_i`  input  1  pipeline flush (branch taken); aborts any operation.
- `rs1_data_i`  input  XLEN  multiplicand.
- `rs2_data_i`  input  XLEN  multiplier.
- `rd_addr_i`  input  5  destination register of the `mul`.
- `stall_o`  output  1  holds the PC, IF/ID and ID/EX registers.
- `busy_o`  output  1  the sequencer is not IDLE.
- `done_o`  output  1  one-cycle pulse; `result_o` and `rd_addr_o` are valid.
- `result_o`  output  XLEN  product bits [XLEN-1:0].
- `rd_addr_o`  output  5  latched destination register.

## Operation
- State machine with three states: IDLE, RUN and DONE. The state is registered.
- IDLE:
  - If `start_i`=1 and `flush_i`=0, the block accepts the operation.
  - On accept it latches `rs1_data_i` into the multiplicand register (mcand), `rs2_data_i` into the multiplier register (mplier) and `rd_addr_i` into the rd register.
  - On accept it clears the accumulator (acc) and the counter, then goes to RUN.
- RUN, each cycle:
  - If mplier[0]=1, then acc ← acc + mcand, truncated to XLEN bits.
  - mcand ← mcand << 1. Bits shifted out of the MSB are discarded.
  - mplier ← mplier >> 1, logical shift.
  - The counter increments.
  - After the XLEN-th iteration the state goes to DONE.
- There is no early termination: every operation takes XLEN RUN cycles.
- Counter width is $clog2(XLEN)+1.
- DONE lasts exactly one cycle, then the state goes to IDLE.
  - `start_i` is ignored in DONE, because that cycle the same instruction is still in EX.
- Only the low XLEN bits of the product are produced. Signed and unsigned results are therefore identical, and no sign handling is required.
- `flush_i`:
  - In RUN or DONE, the next state is IDLE and `done_o` is suppressed that cycle.
  - In IDLE, it blocks acceptance.
  - acc, mcand and mplier are not cleared by a flush.
- `rst_i`, asynchronous: state goes to IDLE and all registers (acc, mcand, mplier, counter, rd) go to 0.
- Output decode:
  - `stall_o` = (IDLE & `start_i` & !`flush_i`) | RUN. This is combinational so the accept cycle is stalled.
  - `busy_o` = state != IDLE.
  - `done_o` = DONE & !`flush_i`.
  - `result_o` = acc.
  - `rd_addr_o` = rd register.

## Timing
- Reset values: `stall_o`=0, `busy_o`=0, `done_o`=0, `result_o`=0, `rd_addr_o`=0.
- The cycle in which `start_i` is accepted is cycle 0.
  - Cycles 1..XLEN are RUN.
  - Cycle XLEN+1 is DONE.
- `stall_o` is high on cycles 0..XLEN, which is XLEN+1 cycles. It is low in DONE, so EX/MEM captures `result_o` at the end of DONE.
- `busy_o` is high on cycles 1..XLEN+1.
- Back-to-back `mul`s: the next instruction reaches EX on cycle XLEN+2 while the block is IDLE, and is accepted there. Its `done_o` follows XLEN+2 cycles after the first `done_o`.
- `result_o` holds its value after DONE until the next accept clears acc. It is meaningful only while `done_o`=1.
- `flush_i` and `start_i` both high in IDLE: the start is not accepted and `stall_o`=0.
- When reset is released, the first accept can occur on the first rising edge with `rst_i`=0.

## Test plan
- Reset: assert `rst_i` with random inputs → all outputs are 0. After release with `start_i`=0, the block stays IDLE for 10 cycles.
- Basic case, XLEN=32: `rs1`=6, `rs2`=7, `rd`=5, `start_i` held until `stall_o` falls:
  - `stall_o`=1 for exactly 33 cycles.
  - `done_o` pulses on cycle 33 with `result_o`=42 and `rd_addr_o`=5.
  - `busy_o` is low the following cycle.
- Wrap-around:
  - 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
  - 0x80000000×2 → 0x00000000.
  - 0x12345678×0 → 0, still taking 32 RUN cycles.
- Flush: assert `flush_i` on cycle 10 of RUN → state is IDLE on the next cycle; `stall_o`=0 and `busy_o`=0, and `done_o` never pulses. A new start with 3×4 then returns 12.
- Back-to-back: hold `start_i` through DONE, then present 5×9 with `rd`=7 on the next cycle:
  - The second operation is accepted exactly once.
  - `done_o` pulses 34 cycles apart, with results 42/5 then 45/7.
- Asynchronous reset mid-RUN: pulse `rst_i` between clock edges on cycle 15 → outputs go to 0 immediately, without waiting for an edge. No `done_o` appears for the aborted operation, and a subsequent 2×3 returns 6.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - iterative shift-add multiply sequencer with pipeline stall
module mul_seq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic [4:0]      rd_q;
    logic            accept;

    assign accept = (state == ST_IDLE) && start_i && !flush_i;

    // Next-state decode; a flush always returns to IDLE, start is ignored in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush_i)
                    state_nxt = ST_IDLE;
                else if (cnt == LAST_ITER)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Shift-add datapath: load on accept, one multiplier bit per RUN cycle;
    // a flushed RUN cycle leaves the operands untouched
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            rd_q   <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= rs1_data_i;
            mplier <= rs2_data_i;
            cnt    <= '0;
            rd_q   <= rd_addr_i;
        end else if (state == ST_RUN && !flush_i) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    // Stall is combinational so the accept cycle itself holds the front end;
    // it is forced low while reset is asserted so all outputs read zero
    assign stall_o   = !rst_i && (accept || (state == ST_RUN));
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE) && !flush_i;
    assign result_o  = acc;
    assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_in = '0;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    mul_seq_ctrl #(.XLEN(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .flush_i    (flush),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .rd_addr_i  (rd_in),
        .stall_o    (stall),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .rd_addr_o  (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_rd"}, 32'(rd_out), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation while IDLE, hold start until stall falls; returns in DONE
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int tdone);
        int n;
        rs1 = a; rs2 = b; rd_in = rd; start = 1'b1; flush = 1'b0;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("stall_len", 32'(n), 32'd33);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("result", result, model_mul(a, b));
        chk("rd_addr", 32'(rd_out), 32'(rd));
        tdone = cyc;
    endtask

    task automatic finish_op();
        start = 1'b0;
        tick();
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    task automatic no_done_for(input string tag, input int ncyc);
        int pulses;
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        int t1, t2, gap;
        logic [31:0] a, b;
        logic [4:0]  r;

        // Reset held with random inputs: every output stays zero
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom); flush = 1'($urandom);
            rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom);
            #3;
            chk_all_zero("reset");
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        // Basic case and wrap-around boundaries
        do_op(32'd6, 32'd7, 5'd5, t1);
        finish_op();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, t1);
        chk("wrap_ff", result, 32'h0000_0001);
        finish_op();
        do_op(32'h8000_0000, 32'd2, 5'd2, t1);
        chk("wrap_msb", result, 32'h0000_0000);
        finish_op();
        do_op(32'h1234_5678, 32'd0, 5'd3, t1);
        finish_op();

        // Start and flush together in IDLE: not accepted
        rs1 = 32'd9; rs2 = 32'd9; rd_in = 5'd4; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_idle_busy", 32'(busy), 32'd0);
        start = 1'b0; flush = 1'b0;
        tick();

        // Flush on RUN cycle 10
        rs1 = 32'd11; rs2 = 32'd13; rd_in = 5'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("flush_run_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_run_done", 32'(done), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        no_done_for("flush_no_done", 40);
        do_op(32'd3, 32'd4, 5'd8, t1);
        chk("after_flush", result, 32'd12);
        finish_op();

        // Back-to-back: start held through DONE, next op presented right after
        do_op(32'd6, 32'd7, 5'd5, t1);
        tick();
        do_op(32'd5, 32'd9, 5'd7, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd34);
        chk("b2b_result", result, 32'd45);
        finish_op();
        no_done_for("b2b_once", 40);

        // Asynchronous reset between edges on RUN cycle 15
        rs1 = 32'h0000_FFFF; rs2 = 32'h0000_0003; rd_in = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst = 1'b0;
        no_done_for("rst_no_done", 40);
        do_op(32'd2, 32'd3, 5'd10, t1);
        chk("after_rst", result, 32'd6);
        finish_op();

        // Random operations against the arithmetic model
        for (int k = 0; k < 8; k++) begin
            a = $urandom; b = $urandom; r = 5'($urandom_range(0, 31));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            do_op(a, b, r, t1);
            finish_op();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
